ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain PS2Clk/datai pair that the existing PS/2 receive path listens on. It runs the full host request-to-send sequence, shifts the frame out on device-generated clock edges, and checks the device ACK. It reports completion or error through a simple start/busy/done/err handshake for the calculator control logic.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles PS2 clock is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles from clock release to ACK before abort (15 ms at 50 MHz)

Ports:
clk  in  1  system clock (FPGA clock domain)
rst  in  1  synchronous reset, active-low
tx_data  in  8  command byte, sampled on accepted tx_start
tx_start  in  1  one-cycle request; accepted only in IDLE
tx_busy  out  1  high from the cycle after acceptance until return to IDLE
tx_done  out  1  one-cycle pulse: frame sent and ACK received
tx_err  out  1  one-cycle pulse: missing ACK or timeout
ps2_clk_in  in  1  sensed PS2 clock line (asynchronous)
ps2_data_in  in  1  sensed PS2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull PS2 clock low; 0 = release
ps2_data_oe  out  1  1 = pull PS2 data low; 0 = release

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_err=0, all counters cleared. A reset mid-frame releases both lines on the next edge.
- Inputs pass through a 2-flop synchronizer. A falling edge is sync2==0 with the previous sample ==1. The design acts on an edge exactly one cycle after it is detected.
- Frame f[0..10]: f0=start 0, f1..f8=tx_data LSB first, f9=odd parity (~^tx_data), f10=stop 1. The data line is driven as ps2_data_oe = ~f[n].
- States:
  - IDLE: both oe=0, busy=0. On tx_start: latch tx_data, go to INHIBIT. tx_busy=1 from the next cycle.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: clk_oe=1, data_oe=1 (f0) for exactly 1 cycle. Then go to SHIFT, release the clock, bit index n=0, start the timeout counter.
  - SHIFT: clk_oe=0. On each detected falling edge, n++ and data_oe=~f[n]. After the edge that makes n=10, data is released (stop bit); go to ACK.
  - ACK: on the next falling edge, sample sync ps2_data_in. If 0, go to WAITIDLE. If 1, pulse tx_err and go to IDLE.
  - WAITIDLE: when sync clock and data are both 1, pulse tx_done and go to IDLE.
- Timeout: counts cycles spent in SHIFT, ACK and WAITIDLE. On reaching TIMEOUT_CYCLES: release both lines, pulse tx_err, go to IDLE. tx_done and tx_err are never both high.
- tx_start while busy is ignored, and tx_data is not re-sampled.
- tx_done or tx_err is asserted in the same cycle busy drops. A new tx_start is accepted on the following cycle.

Test Plan:
(Bench uses INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, and a device model clocking at 40 clk cycles per half-period.)
- Inhibit/RTS timing: tx_start, tx_data=0xED -> busy next cycle; clk_oe=1 for exactly 8 cycles; then 1 cycle with clk_oe=1 and data_oe=1; then clk_oe=0 and data_oe=1.
- 0xED send: device samples on rising edges 1,0,1,1,0,1,1,1, parity 1, stop 1. Device drives ACK low -> one tx_done pulse, no tx_err, both oe=0.
- Parity sweep: 0x00 -> parity 1; 0x01 -> 0; 0xFF -> 1; 0x80 -> 0. Each is received correctly by the device model.
- No ACK: device leaves data high on the 11th edge -> tx_err pulse, no tx_done, lines released, IDLE.
- Timeout: device never clocks -> tx_err exactly TIMEOUT_CYCLES after clock release, both oe=0.
- Busy and reset: second tx_start mid-frame is ignored and the frame completes with the original byte. rst=0 at bit 4 -> next cycle all outputs 0; a subsequent 0xFF send completes with tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard over the open-drain PS/2 clock/data pair. It holds the
// clock low to inhibit the device, then issues request-to-send. It shifts the frame out on
// device-generated falling edges and checks the device ACK.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   tx_data      command byte, latched when tx_start is accepted
//   tx_start     one-cycle request, accepted only when idle
//   tx_busy      high while a transfer is in progress
//   tx_done      one-cycle pulse: frame sent and ACK received
//   tx_err       one-cycle pulse: missing ACK or timeout
//   ps2_clk_in   sensed PS/2 clock line (asynchronous)
//   ps2_data_in  sensed PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // One counter serves both the inhibit interval and the ACK timeout; they never overlap.
  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StShift,
    StAck,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [10:0]     frame_q, frame_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic fall_q;
  logic fall;
  logic in_ack_window;

  assign fall          = clk_prev_q & ~clk_s2_q;
  assign in_ack_window = (state_q == StShift) || (state_q == StAck) || (state_q == StWaitIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (tx_start) begin
          // f0 start, f1..f8 data LSB first, f9 odd parity, f10 stop
          frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StRts;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRts: begin
        bit_d   = 4'd0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (fall_q) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        cnt_d = cnt_q + 1'b1;
        if (fall_q) begin
          if (!data_s2_q) begin
            state_d = StWaitIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWaitIdle: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_s2_q && data_s2_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout overrides any progress made in the same cycle.
    if (in_ack_window && (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
      state_d = StIdle;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  // Line drivers are decoded from the next state so they are glitch-free registers that change
  // in the same cycle as the state.
  always_comb begin
    busy_d    = (state_d != StIdle);
    clk_oe_d  = (state_d == StInhibit) || (state_d == StRts);
    data_oe_d = (state_d == StRts) || ((state_d == StShift) && !frame_d[bit_d]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      frame_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      // Idle-high reset values avoid a spurious falling edge after reset.
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
      fall_q     <= fall;
    end
  end

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
